// File: rtl/adbg_or1k_pkg.sv
// Shared types for the OR1K debug run-control block.
package adbg_or1k_pkg;

  typedef enum logic [1:0] {
    CMD_HALT   = 2'd0,
    CMD_RESUME = 2'd1,
    CMD_STEP   = 2'd2,
    CMD_RESET  = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RST  = 2'd2
  } halt_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adbg_or1k_dncnt.sv
// Loadable down-counter that saturates at zero and flags a count of one.
module adbg_or1k_dncnt #(
  parameter int unsigned W = 8
) (
  input  logic         cpu_clk_i,
  input  logic         cpu_rstn_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc_c = (cnt_q == W'(1));

endmodule

// File: rtl/adbg_or1k_halt_ctrl.sv
// Multi-core halt/resume/step/reset sequencer with breakpoint latching.
// Group cross-halt is enabled by defining ADBG_OR1K_CROSS_TRIGGER_EN.
module adbg_or1k_halt_ctrl
  import adbg_or1k_pkg::*;
#(
  parameter int unsigned NB_CORES   = 4,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic                cpu_clk_i,
  input  logic                cpu_rstn_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [NB_CORES-1:0] cmd_mask_i,
  input  logic [STEP_W-1:0]   step_len_i,
  input  logic [NB_CORES-1:0] group_mask_i,
  input  logic [NB_CORES-1:0] bp_i,
  output logic [NB_CORES-1:0] stall_o,
  output logic [NB_CORES-1:0] rst_o,
  output logic [NB_CORES-1:0] halted_o,
  output logic [NB_CORES-1:0] bp_hit_o,
  output logic                busy_o
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned CNT_W = max_u(STEP_W, RST_W);

  halt_state_t         state_q, state_d;
  logic [NB_CORES-1:0] stall_q, stall_d;
  logic [NB_CORES-1:0] bp_hit_q, bp_hit_d;
  logic [NB_CORES-1:0] rst_q, rst_d;
  logic [NB_CORES-1:0] step_mask_q, step_mask_d;
  logic [NB_CORES-1:0] xtrig_c;
  logic [NB_CORES-1:0] bp_eff_c;
  logic                cnt_load_c;
  logic [CNT_W-1:0]    cnt_val_c;
  logic                cnt_tc_c;

`ifdef ADBG_OR1K_CROSS_TRIGGER_EN
  assign xtrig_c = (|(bp_i & group_mask_i)) ? group_mask_i : '0;
`else
  logic unused_group_c;
  assign unused_group_c = ^group_mask_i;
  assign xtrig_c        = '0;
`endif

  assign bp_eff_c = bp_i | xtrig_c;

  // Shared by STEP and RST; they never overlap.
  adbg_or1k_dncnt #(
    .W (CNT_W)
  ) u_dncnt (
    .cpu_clk_i  (cpu_clk_i),
    .cpu_rstn_i (cpu_rstn_i),
    .load       (cnt_load_c),
    .load_val   (cnt_val_c),
    .dec        (state_q != ST_IDLE),
    .tc_c       (cnt_tc_c)
  );

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      state_q     <= ST_IDLE;
      stall_q     <= '0;
      bp_hit_q    <= '0;
      rst_q       <= '0;
      step_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      bp_hit_q    <= bp_hit_d;
      rst_q       <= rst_d;
      step_mask_q <= step_mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_d     = stall_q;
    bp_hit_d    = bp_hit_q;
    rst_d       = rst_q;
    step_mask_d = step_mask_q;
    cnt_load_c  = 1'b0;
    cnt_val_c   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          unique case (cmd_op_t'(cmd_op_i))
            CMD_HALT: stall_d = stall_q | cmd_mask_i;
            CMD_RESUME: begin
              stall_d  = stall_q & ~cmd_mask_i;
              bp_hit_d = bp_hit_q & ~cmd_mask_i;
            end
            CMD_STEP: begin
              step_mask_d = cmd_mask_i & stall_q;
              stall_d     = stall_q & ~cmd_mask_i;
              cnt_load_c  = 1'b1;
              cnt_val_c   = (step_len_i == '0) ? CNT_W'(1) : CNT_W'(step_len_i);
              state_d     = ST_STEP;
            end
            CMD_RESET: begin
              rst_d      = rst_q | cmd_mask_i;
              stall_d    = stall_q | cmd_mask_i;
              bp_hit_d   = bp_hit_q & ~cmd_mask_i;
              cnt_load_c = 1'b1;
              cnt_val_c  = CNT_W'(RST_CYCLES);
              state_d    = ST_RST;
            end
          endcase
        end
      end
      ST_STEP: begin
        // An empty step mask just retires the command after one cycle.
        if (cnt_tc_c || (step_mask_q == '0) || (|(bp_eff_c & step_mask_q))) begin
          stall_d = stall_q | step_mask_q;
          state_d = ST_IDLE;
        end
      end
      ST_RST: begin
        if (cnt_tc_c) begin
          rst_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Breakpoints override any same-cycle command clear.
    stall_d  = stall_d | bp_eff_c;
    bp_hit_d = bp_hit_d | bp_i;
  end

  assign stall_o     = stall_q | bp_eff_c;
  assign halted_o    = stall_q;
  assign bp_hit_o    = bp_hit_q;
  assign rst_o       = rst_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign cmd_ready_o = (state_q == ST_IDLE);

endmodule

// File: tb/tb_adbg_or1k_halt_ctrl.sv
// Bench for adbg_or1k_halt_ctrl: directed checks plus randomized traffic against a cycle model.
module tb_adbg_or1k_halt_ctrl;

  localparam int NB  = 4;
  localparam int RSTC = 16;
`ifdef ADBG_OR1K_CROSS_TRIGGER_EN
  localparam bit XT = 1'b1;
`else
  localparam bit XT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [NB-1:0] cmd_mask = '0;
  logic [7:0]    step_len = '0;
  logic [NB-1:0] group = '0;
  logic [NB-1:0] bp = '0;
  logic [NB-1:0] stall, rst_v, halted, bp_hit;
  logic          busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  adbg_or1k_halt_ctrl #(.NB_CORES(NB), .STEP_W(8), .RST_CYCLES(RSTC)) dut (
    .cpu_clk_i   (clk),
    .cpu_rstn_i  (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_mask_i  (cmd_mask),
    .step_len_i  (step_len),
    .group_mask_i(group),
    .bp_i        (bp),
    .stall_o     (stall),
    .rst_o       (rst_v),
    .halted_o    (halted),
    .bp_hit_o    (bp_hit),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Model: per-core bit vectors plus a count of busy cycles still to run.
  logic [NB-1:0] m_stall = '0, m_bphit = '0, m_rst = '0, m_smask = '0;
  int            m_left = 0;
  bit            m_is_step = 1'b0;

  function automatic logic [NB-1:0] bp_eff(input logic [NB-1:0] b, input logic [NB-1:0] g);
    return (XT && ((b & g) != '0)) ? (b | g) : b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stall = '0; m_bphit = '0; m_rst = '0; m_smask = '0; m_left = 0; m_is_step = 1'b0;
    end else begin
      logic [NB-1:0] be;
      be = bp_eff(bp, group);
      if (m_left == 0) begin
        if (cmd_valid) begin
          case (cmd_op)
            2'd0: m_stall = m_stall | cmd_mask;
            2'd1: begin m_stall = m_stall & ~cmd_mask; m_bphit = m_bphit & ~cmd_mask; end
            2'd2: begin
              m_smask   = cmd_mask & m_stall;
              m_stall   = m_stall & ~cmd_mask;
              m_is_step = 1'b1;
              if (m_smask == '0)      m_left = 1;
              else if (step_len == 0) m_left = 1;
              else                    m_left = int'(step_len);
            end
            default: begin
              m_rst = m_rst | cmd_mask; m_stall = m_stall | cmd_mask;
              m_bphit = m_bphit & ~cmd_mask; m_is_step = 1'b0; m_left = RSTC;
            end
          endcase
        end
      end else begin
        m_left = m_left - 1;
        if (m_is_step && ((be & m_smask) != '0)) m_left = 0;
        if (m_left == 0) begin
          if (m_is_step) m_stall = m_stall | m_smask;
          else           m_rst = '0;
        end
      end
      m_stall = m_stall | be;
      m_bphit = m_bphit | bp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall",  32'(stall),  32'(m_stall | bp_eff(bp, group)));
      chk("cyc_halted", 32'(halted), 32'(m_stall));
      chk("cyc_rst",    32'(rst_v),  32'(m_rst));
      chk("cyc_bphit",  32'(bp_hit), 32'(m_bphit));
      chk("cyc_busy",   32'(busy),   32'(m_left != 0));
      chk("cyc_ready",  32'(cmd_ready), 32'(m_left == 0));
    end
  end

  task automatic step_clk();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [NB-1:0] mask, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; step_len = len;
    step_clk();
    cmd_valid = 1'b0;
  endtask

  initial begin
    step_clk();
    step_clk();
    chk_en = 1'b1;
    // Reset state with no breakpoints.
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_busy",  32'(busy), 32'h0);
    rst_n = 1'b1;
    step_clk();

    drive_cmd(2'd0, 4'b0101, 8'd0);
    chk("halt_0101", 32'(stall), 32'h5);

    drive_cmd(2'd0, 4'b1111, 8'd0);
    drive_cmd(2'd2, 4'b0010, 8'd3);
    for (int i = 0; i < 3; i++) begin
      chk("step_run_stall", 32'(stall), 32'hd);
      chk("step_run_ready", 32'(cmd_ready), 32'h0);
      step_clk();
    end
    chk("step_end_stall", 32'(stall), 32'hf);
    chk("step_end_ready", 32'(cmd_ready), 32'h1);
    chk("step_end_bphit", 32'(bp_hit), 32'h0);

    drive_cmd(2'd1, 4'b1111, 8'd0);
    group = 4'b1110;
    bp = 4'b0100;
    #1;
    chk("bp_comb_stall", 32'(stall), XT ? 32'he : 32'h4);
    step_clk();
    bp = '0;
    #1;
    chk("bp_reg_stall", 32'(stall), XT ? 32'he : 32'h4);
    chk("bp_reg_bphit", 32'(bp_hit), 32'h4);
    chk("bp_core0_run", 32'(halted[0]), 32'h0);

    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_mask = 4'b0100; bp = 4'b0100;
    step_clk();
    cmd_valid = 1'b0; bp = '0;
    chk("bp_wins_halt",  32'(halted[2]), 32'h1);
    chk("bp_wins_bphit", 32'(bp_hit[2]), 32'h1);
    drive_cmd(2'd1, 4'b0100, 8'd0);
    chk("resume_clr_bphit", 32'(bp_hit[2]), 32'h0);

    bp = 4'b1000;
    step_clk();
    bp = '0;
    chk("pre_reset_bphit", 32'(bp_hit[3]), 32'h1);
    drive_cmd(2'd3, 4'b1000, 8'd0);
    for (int i = 0; i < RSTC; i++) begin
      chk("reset_rst", 32'(rst_v), 32'h8);
      chk("reset_busy", 32'(busy), 32'h1);
      step_clk();
    end
    chk("reset_done_rst",   32'(rst_v), 32'h0);
    chk("reset_done_busy",  32'(busy), 32'h0);
    chk("reset_done_stall", 32'(stall[3]), 32'h1);
    chk("reset_done_bphit", 32'(bp_hit[3]), 32'h0);

    drive_cmd(2'd0, 4'b1111, 8'd0);
    drive_cmd(2'd2, 4'b0001, 8'd200);
    repeat (99) step_clk();
    chk("long_step_run", 32'(stall[0]), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_stall", 32'(stall), 32'h0);
    chk("async_halted", 32'(halted), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_ready", 32'(cmd_ready), 32'h1);
    step_clk();
    step_clk();
    rst_n = 1'b1;
    step_clk();
    drive_cmd(2'd0, 4'b0011, 8'd0);
    chk("post_rst_halt", 32'(stall), 32'h3);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_mask  = NB'($urandom);
      step_len  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
      bp = '0;
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 19) == 0) bp[b] = 1'b1;
      if ((c % 250) == 0) group = NB'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        step_clk();
        step_clk();
        rst_n = 1'b1;
      end
      step_clk();
    end
    cmd_valid = 1'b0;
    bp = '0;
    step_clk();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adbg_or1k_halt_ctrl.md
# adbg_or1k_halt_ctrl

Multi-core run-control sequencer in the CPU clock domain. It turns host run-control commands (halt, resume, single-step, reset) into per-core stall and reset levels, latches breakpoint causes, and optionally cross-halts a core group when any member hits a breakpoint. It sits between the synchronised debug-host command path and the cores' stall/reset inputs. It owns the stall/reset state that the host previously wrote directly as per-core bits.

## Interface
- NB_CORES, 4, number of controlled cores (1..32)
- STEP_W, 8, width of the step-length field and counter
- RST_CYCLES, 16, cycles that rst_o is held per RESET command (>=1)
- cpu_clk_i  in  1  CPU clock; sole clock of the block
- cpu_rstn_i  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command strobe
- cmd_ready_o  out  1  high only in IDLE; a command is accepted when cmd_valid_i & cmd_ready_o at a rising edge
- cmd_op_i  in  2  command: HALT=0, RESUME=1, STEP=2, RESET=3
- cmd_mask_i  in  NB_CORES  cores targeted by the command
- step_len_i  in  STEP_W  run cycles per STEP; sampled on accept; 0 is treated as 1
- group_mask_i  in  NB_CORES  cross-halt group membership (static while cores run)
- bp_i  in  NB_CORES  per-core breakpoint pulse or level
- stall_o  out  NB_CORES  per-core stall
- rst_o  out  NB_CORES  per-core reset; must never drive cpu_rstn_i
- halted_o  out  NB_CORES  registered stall state, excluding combinational bp terms
- bp_hit_o  out  NB_CORES  sticky "stopped by breakpoint" flag
- busy_o  out  1  high in STEP or RST

## Operation
- Per-core state registers:
  - stall_q
  - bp_hit_q
  - rst_q
- Single FSM with three states:
  - IDLE
  - STEP: down-counter of STEP_W bits, plus step_mask_q
  - RST: counter up to RST_CYCLES
- IDLE commands:
  - HALT: stall_q |= mask. Stays in IDLE.
  - RESUME: stall_q &= ~mask; bp_hit_q &= ~mask. Stays in IDLE.
  - STEP: step_mask_q = mask & stall_q; stall_q &= ~mask; load counter = max(step_len_i,1); go to STEP. If step_mask_q is 0, the command completes in one cycle with no effect.
  - RESET: rst_q |= mask; stall_q |= mask; bp_hit_q &= ~mask; load counter; go to RST.
- STEP:
  - Decrement the counter every cycle.
  - At count 1, or on a breakpoint from any stepped core: stall_q |= step_mask_q, go to IDLE.
- RST:
  - At count 1: rst_q cleared, go to IDLE.
  - Targeted cores stay halted after reset.
- Breakpoint handling runs every cycle in every state. It has priority over any command clear in the same cycle:
  - bp_i[i] sets stall_q[i] and bp_hit_q[i].
  - With cross-trigger, a bp on any group member also sets stall_q for the whole group; bp_hit is set only for the hitting core.
- stall_o = stall_q | bp_i | xtrig, where xtrig = group_mask_i replicated when |(bp_i & group_mask_i).
  - The breakpoint stall is combinational, with zero-cycle latency.
- Reset mid-operation: cpu_rstn_i low forces IDLE immediately and clears all registers and outputs asynchronously; any in-flight STEP or RESET is abandoned.
- Commands with cmd_mask_i = 0 are accepted and have no effect.

## Timing
- Reset values:
  - stall_o = bp_i-derived terms only
  - rst_o = 0, halted_o = 0, bp_hit_o = 0, busy_o = 0
  - cmd_ready_o = 1
- HALT/RESUME accepted at edge N: stall_o/halted_o change after edge N (one-cycle latency).
- STEP with length L accepted at edge N:
  - Targeted cores are unstalled for exactly L cycles, between edges N and N+L.
  - They are re-stalled after edge N+L.
  - cmd_ready_o is low for those L cycles.
- RESET accepted at edge N: rst_o is high for exactly RST_CYCLES cycles, then returns to 0; busy_o is high for the same window.
- Counters never wrap: the STEP counter is loaded with 1..2^STEP_W-1, and the RST counter saturates at the terminal value.

## Configuration
- ADBG_OR1K_CROSS_TRIGGER_EN defined: group cross-halt as described.
- ADBG_OR1K_CROSS_TRIGGER_EN undefined:
  - group_mask_i is ignored and xtrig is 0.
  - A breakpoint stalls only its own core.
  - An early STEP stop triggers only on a stepped core's own bp.

## Structure
- Shared package adbg_or1k_pkg:
  - cmd_op_t enum (HALT/RESUME/STEP/RESET)
  - halt_state_t enum (IDLE/STEP/RST)
- Sub-module adbg_or1k_dncnt: a loadable, saturating down-counter with a terminal-count flag. It is instantiated once and shared by STEP and RST, since the two are mutually exclusive.

## Test plan
- Reset with bp_i = 0: all outputs 0 and cmd_ready_o = 1. HALT with mask 4'b0101: stall_o = 4'b0101 one cycle after accept.
- From all halted, STEP mask 4'b0010 with step_len 3: stall_o[1] low for exactly 3 cycles then high; cmd_ready_o low for those 3 cycles; bp_hit_o stays 0.
- With cross-trigger on, group 4'b1110 and all running: a bp_i[2] pulse gives stall_o = 4'b1110 in the same cycle and registered afterwards; bp_hit_o = 4'b0100; core 0 keeps running.
- RESUME mask 4'b0100 in the same cycle that bp_i[2] = 1: stall_o[2] stays 1 and bp_hit_o[2] stays 1 (bp wins).
- RESET mask 4'b1000 with RST_CYCLES = 16: rst_o[3] high for exactly 16 cycles, stall_o[3] high afterwards, bp_hit_o[3] cleared.
- Drop cpu_rstn_i halfway through a STEP of length 200: all outputs reset asynchronously; after release the FSM is in IDLE and the next HALT completes normally.
